vcve2_data_arbiter: RTL and testbench
=====================================

VCVE2_DATA_ARBITER -- requirements
Module: vcve2_data_arbiter

Interface
REQ-001 Parameter NumIfs, default 2: number of core data request ports; legal range 2..8.
REQ-002 Parameter MaxOutstanding, default 2: maximum number of granted requests awaiting response; legal range 1..4.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 core_req_i  input  NumIfs  per-port request valid.
REQ-006 core_gnt_o  output  NumIfs  per-port grant; one-hot or zero.
REQ-007 core_we_i, core_be_i[4], core_addr_i[32], core_wdata_i[32]  input  per-port (packed NumIfs arrays)  request payload.
REQ-008 core_rvalid_o  output  NumIfs  per-port response valid; one-hot or zero.
REQ-009 core_rdata_o  output  32  response data, shared by all ports; qualified by core_rvalid_o.
REQ-010 core_err_o  output  1  response error, shared by all ports; qualified by core_rvalid_o.
REQ-011 mem_req_o, mem_we_o, mem_be_o[4], mem_addr_o[32], mem_wdata_o[32]  output  single memory-port request.
REQ-012 mem_gnt_i, mem_rvalid_i, mem_rdata_i[32], mem_err_i  input  single memory-port handshake and response.
REQ-013 outstanding_o  output  3  count of granted, unanswered requests.
REQ-014 proto_err_o  output  1  sticky flag: mem_rvalid_i arrived with no outstanding request.

Function
REQ-015 The arbiter SHALL use round-robin selection among asserted core_req_i, starting the search at the port after the last granted port; after reset the search starts at port 0.
REQ-016 mem_req_o SHALL be high only when a port is selected and outstanding_o < MaxOutstanding; mem payload SHALL equal the selected port's payload (combinational path, zero latency).
REQ-017 Lock: once mem_req_o is high for port k and mem_gnt_i is low, port k SHALL stay selected until granted, regardless of other requests.
REQ-018 core_gnt_o[k] SHALL equal mem_gnt_i AND mem_req_o AND (selected == k) in the same cycle.
REQ-019 On each grant, the granted index SHALL be pushed into an in-order ID FIFO of depth MaxOutstanding, and the round-robin pointer SHALL advance to k+1 modulo NumIfs (wrap to 0).
REQ-020 On mem_rvalid_i with FIFO non-empty: core_rvalid_o[head] SHALL be asserted in the same cycle, core_rdata_o/core_err_o SHALL equal mem_rdata_i/mem_err_i, and the head SHALL be popped.
REQ-021 Full: with outstanding_o == MaxOutstanding, mem_req_o SHALL be low even if mem_rvalid_i is high in that cycle; no bypass.
REQ-022 A grant and a response in the same cycle SHALL push and pop; outstanding_o SHALL stay unchanged.
REQ-023 mem_rvalid_i with FIFO empty SHALL set proto_err_o, SHALL NOT assert any core_rvalid_o, and SHALL leave outstanding_o at 0.
REQ-024 Index width SHALL be max(1, clog2(NumIfs)); pointer arithmetic SHALL wrap modulo NumIfs, not modulo a power of two.
REQ-025 With no request pending, mem payload outputs SHALL be driven to 0.

Reset
REQ-026 Reset values: round-robin pointer 0, lock clear, FIFO empty, outstanding_o 0, proto_err_o 0; all grant and rvalid outputs 0.
REQ-027 Reset asserted mid-transaction SHALL discard all outstanding IDs; responses arriving after reset release SHALL be treated as described in REQ-023.
REQ-028 proto_err_o SHALL clear only on reset.

Structure
REQ-029 The constants MaxIfs = 8 and MaxOutstandingLimit = 4 SHALL live in vcve2_pkg, together with typedef arb_idx_t (3-bit port index).
REQ-030 The ID FIFO SHALL be a sub-module, vcve2_arb_id_fifo, with push/pop/full/empty/count and the same clock and reset.
REQ-031 Arbitration, lock and response routing SHALL reside in vcve2_data_arbiter; no other sub-modules.

Verification
REQ-032 Ports 0 and 1 request continuously, mem_gnt_i = 1, rvalid one cycle later -> grants alternate 0,1,0,1; responses route to the same order.
REQ-033 Port 1 requests, mem_gnt_i held low for 3 cycles, port 0 raises a request during that time -> port 1 stays selected with a stable payload; port 1 is granted on cycle 4.
REQ-034 MaxOutstanding = 2, two grants with no rvalid -> mem_req_o low and outstanding_o = 2; rvalid in the next cycle still gives no grant that cycle; a grant follows one cycle later.
REQ-035 Grant and rvalid in the same cycle with outstanding_o = 1 -> outstanding_o stays 1; rvalid goes to the older port.
REQ-036 NumIfs = 3, last grant to port 2 -> next search starts at port 0 (wrap).
REQ-037 mem_rvalid_i pulse after reset with no request -> proto_err_o = 1, core_rvalid_o = 0; rst_i then clears proto_err_o.

Source files
------------

// File: rtl/vcve2_pkg.sv
// Shared constants and types for the vcve2 data-port arbiter.
// Holds port/outstanding limits, the port index type and the lock state encoding.
package vcve2_pkg;

    localparam int unsigned MaxIfs              = 8;
    localparam int unsigned MaxOutstandingLimit = 4;

    typedef logic [2:0] arb_idx_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Successor of a port index, wrapping at num_ifs rather than at a power of two.
    function automatic arb_idx_t next_idx(input arb_idx_t idx, input int unsigned num_ifs);
        if (32'(idx) + 32'd1 >= num_ifs) begin
            return '0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/vcve2_arb_id_fifo.sv
// In-order FIFO of granted port indices awaiting a memory response.
// Push and pop in the same cycle leave the occupancy unchanged.
module vcve2_arb_id_fifo
    import vcve2_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [2:0]       count_o
);

    localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [2:0]      DepthCnt = 3'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [2:0]       count_q;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // NOTE: storage has no reset; entries are only read when count_q says they were written.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vcve2_data_arbiter.sv
// Round-robin arbiter merging NumIfs core data ports onto one memory port,
// with request lock until grant and in-order response routing.
module vcve2_data_arbiter
    import vcve2_pkg::*;
#(
    parameter int unsigned NumIfs         = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [NumIfs-1:0]       core_req_i,
    output logic [NumIfs-1:0]       core_gnt_o,
    input  logic [NumIfs-1:0]       core_we_i,
    input  logic [NumIfs-1:0][3:0]  core_be_i,
    input  logic [NumIfs-1:0][31:0] core_addr_i,
    input  logic [NumIfs-1:0][31:0] core_wdata_i,
    output logic [NumIfs-1:0]       core_rvalid_o,
    output logic [31:0]             core_rdata_o,
    output logic                    core_err_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [3:0]              mem_be_o,
    output logic [31:0]             mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_rdata_i,
    input  logic                    mem_err_i,

    output logic [2:0]              outstanding_o,
    output logic                    proto_err_o
);

    localparam int unsigned IdxW   = (NumIfs > 1) ? $clog2(NumIfs) : 1;
    localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);

    if (NumIfs < 2 || NumIfs > MaxIfs) begin : g_bad_num_ifs
        $error("vcve2_data_arbiter: NumIfs out of range");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > MaxOutstandingLimit) begin : g_bad_max_out
        $error("vcve2_data_arbiter: MaxOutstanding out of range");
    end

    arb_state_e      state_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic            proto_err_q;

    logic [IdxW-1:0] rr_idx;
    logic            rr_found;
    logic [IdxW-1:0] sel_idx;
    logic            sel_valid;
    logic            can_issue;
    logic            grant;

    logic [IdxW-1:0] head_idx;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2:0]      fifo_count;
    logic            resp_valid;

    // Search every port once, starting at rr_ptr_q and wrapping at NumIfs.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int unsigned cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int i = 0; i < int'(NumIfs); i++) begin
            cand = 32'(rr_ptr_q) + 32'(i);
            if (cand >= NumIfs) begin
                cand = cand - NumIfs;
            end
            if (!rr_found && core_req_i[IdxW'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IdxW'(cand);
            end
        end
    end

    // A request that was presented but not granted keeps its port until accepted.
    assign sel_idx   = (state_q == ARB_LOCKED) ? lock_idx_q : rr_idx;
    assign sel_valid = (state_q == ARB_LOCKED) | rr_found;
    assign can_issue = (fifo_count < MaxOut);
    assign mem_req_o = sel_valid & can_issue;
    assign grant     = mem_req_o & mem_gnt_i;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (sel_valid) begin
            mem_we_o    = core_we_i[sel_idx];
            mem_be_o    = core_be_i[sel_idx];
            mem_addr_o  = core_addr_i[sel_idx];
            mem_wdata_o = core_wdata_i[sel_idx];
        end
    end

    always_comb begin
        core_gnt_o          = '0;
        core_gnt_o[sel_idx] = grant;
    end

    assign resp_valid = mem_rvalid_i & ~fifo_empty;

    always_comb begin
        core_rvalid_o           = '0;
        core_rvalid_o[head_idx] = resp_valid;
    end

    assign core_rdata_o  = mem_rdata_i;
    assign core_err_o    = mem_err_i;
    assign outstanding_o = fifo_count;
    assign proto_err_o   = proto_err_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_FREE;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_FREE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q    <= ARB_LOCKED;
                        lock_idx_q <= sel_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (grant) begin
                        state_q <= ARB_FREE;
                    end
                end
                default: state_q <= ARB_FREE;
            endcase
            if (grant) begin
                rr_ptr_q <= IdxW'(next_idx(arb_idx_t'(sel_idx), NumIfs));
            end
            if (mem_rvalid_i && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    vcve2_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (grant),
        .push_data_i (sel_idx),
        .pop_i       (resp_valid),
        .head_o      (head_idx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_vcve2_data_arbiter.sv
// Directed bench for vcve2_data_arbiter with three ports and two outstanding requests.
module tb_vcve2_data_arbiter;

    localparam int unsigned NI = 3;

    logic              clk;
    logic              rst;
    logic [NI-1:0]       core_req;
    logic [NI-1:0]       core_gnt;
    logic [NI-1:0]       core_we;
    logic [NI-1:0][3:0]  core_be;
    logic [NI-1:0][31:0] core_addr;
    logic [NI-1:0][31:0] core_wdata;
    logic [NI-1:0]       core_rvalid;
    logic [31:0]         core_rdata;
    logic                core_err;
    logic                mem_req;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [31:0]         mem_rdata;
    logic                mem_err;
    logic [2:0]          outstanding;
    logic                proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    vcve2_data_arbiter #(
        .NumIfs         (NI),
        .MaxOutstanding (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .core_req_i    (core_req),
        .core_gnt_o    (core_gnt),
        .core_we_i     (core_we),
        .core_be_i     (core_be),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .core_err_o    (core_err),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .outstanding_o (outstanding),
        .proto_err_o   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int p);
        return 32'h1000_0000 + 32'(p) * 32'h100;
    endfunction

    task automatic check_payload(input string tag, input int p);
        check({tag, ".addr"},  mem_addr,  addr_of(p));
        check({tag, ".wdata"}, mem_wdata, 32'hD000_0000 + 32'(p));
        check({tag, ".be"},    {28'd0, mem_be}, 32'(4'b0001 << p));
        check({tag, ".we"},    {31'd0, mem_we}, 32'(p % 2));
    endtask

    // Inputs change one unit after the rising edge; outputs are sampled mid-cycle.
    task automatic drive(input logic [NI-1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rdata, input logic err);
        core_req   = req;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rdata;
        mem_err    = err;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NI-1:0] exp_gnt [4];
    logic [NI-1:0] exp_rv  [4];

    initial begin
        for (int p = 0; p < int'(NI); p++) begin
            core_addr[p]  = addr_of(p);
            core_wdata[p] = 32'hD000_0000 + 32'(p);
            core_be[p]    = 4'(4'b0001 << p);
            core_we[p]    = (p % 2 == 1);
        end
        exp_gnt = '{3'b001, 3'b010, 3'b001, 3'b010};
        exp_rv  = '{3'b000, 3'b001, 3'b010, 3'b001};

        // Reset values
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("rst.outstanding", 32'(outstanding), 32'd0);
        check("rst.proto_err",   32'(proto_err),   32'd0);
        check("rst.gnt",         32'(core_gnt),    32'd0);
        check("rst.rvalid",      32'(core_rvalid), 32'd0);
        check("rst.mem_req",     32'(mem_req),     32'd0);
        check("rst.mem_addr",    mem_addr,         32'd0);
        rst = 1'b0;
        tick();

        // Ports 0 and 1 stream, grants alternate and responses follow one cycle later
        for (int i = 0; i < 4; i++) begin
            drive(3'b011, 1'b1, (i > 0), 32'hA000_0000 + 32'(i), 1'b0);
            check($sformatf("rr%0d.gnt", i),    32'(core_gnt),    32'(exp_gnt[i]));
            check($sformatf("rr%0d.rvalid", i), 32'(core_rvalid), 32'(exp_rv[i]));
            check($sformatf("rr%0d.outst", i),  32'(outstanding), (i == 0) ? 32'd0 : 32'd1);
            check_payload($sformatf("rr%0d", i), i % 2);
            if (i > 0) check($sformatf("rr%0d.rdata", i), core_rdata, 32'hA000_0000 + 32'(i));
            tick();
        end
        drive(3'b000, 1'b0, 1'b1, 32'hA000_0004, 1'b0);
        check("rr_drain.rvalid",  32'(core_rvalid), 32'b010);
        check("rr_drain.mem_req", 32'(mem_req),     32'd0);
        check("rr_drain.addr0",   mem_addr,         32'd0);
        tick();
        drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
        check("rr_drain.outst", 32'(outstanding), 32'd0);

        // Lock: port 1 held while port 0 appears; granted on the fourth cycle
        drive(3'b010, 1'b0, 1'b0, '0, 1'b0);
        check("lock1.mem_req", 32'(mem_req),  32'd1);
        check("lock1.gnt",     32'(core_gnt), 32'd0);
        check_payload("lock1", 1);
        tick();
        for (int c = 2; c <= 3; c++) begin
            drive(3'b011, 1'b0, 1'b0, '0, 1'b0);
            check($sformatf("lock%0d.mem_req", c), 32'(mem_req),  32'd1);
            check($sformatf("lock%0d.gnt", c),     32'(core_gnt), 32'd0);
            check_payload($sformatf("lock%0d", c), 1);
            tick();
        end
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        check("lock4.gnt", 32'(core_gnt), 32'b010);
        check_payload("lock4", 1);
        tick();

        // Full: second grant fills the FIFO, a response does not bypass
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        check("full1.outst", 32'(outstanding), 32'd1);
        check("full1.gnt",   32'(core_gnt),    32'b001);
        tick();
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        check("full2.outst",   32'(outstanding), 32'd2);
        check("full2.mem_req", 32'(mem_req),     32'd0);
        check("full2.gnt",     32'(core_gnt),    32'd0);
        tick();
        drive(3'b011, 1'b1, 1'b1, 32'hC000_0001, 1'b0);
        check("full3.mem_req", 32'(mem_req),     32'd0);
        check("full3.gnt",     32'(core_gnt),    32'd0);
        check("full3.rvalid",  32'(core_rvalid), 32'b010);
        check("full3.rdata",   core_rdata,       32'hC000_0001);
        tick();
        drive(3'b011, 1'b1, 1'b0, '0, 1'b0);
        check("full4.outst",   32'(outstanding), 32'd1);
        check("full4.mem_req", 32'(mem_req),     32'd1);
        check("full4.gnt",     32'(core_gnt),    32'b010);
        tick();
        drive(3'b000, 1'b0, 1'b1, 32'hC000_0002, 1'b1);
        check("full5.rvalid", 32'(core_rvalid), 32'b001);
        check("full5.err",    32'(core_err),    32'd1);
        check("full5.outst",  32'(outstanding), 32'd2);
        tick();
        drive(3'b000, 1'b0, 1'b1, 32'hC000_0003, 1'b0);
        check("full6.rvalid", 32'(core_rvalid), 32'b010);
        check("full6.err",    32'(core_err),    32'd0);
        tick();
        drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
        check("full7.outst", 32'(outstanding), 32'd0);

        // Wrap: grant port 2, next search begins at port 0
        drive(3'b100, 1'b1, 1'b0, '0, 1'b0);
        check("wrap1.gnt", 32'(core_gnt), 32'b100);
        check_payload("wrap1", 2);
        tick();
        drive(3'b111, 1'b1, 1'b0, '0, 1'b0);
        check("wrap2.gnt", 32'(core_gnt), 32'b001);
        check_payload("wrap2", 0);
        tick();
        drive(3'b000, 1'b0, 1'b1, 32'hE000_0000, 1'b0);
        check("wrap3.rvalid", 32'(core_rvalid), 32'b100);
        tick();
        drive(3'b000, 1'b0, 1'b1, 32'hE000_0001, 1'b0);
        check("wrap4.rvalid", 32'(core_rvalid), 32'b001);
        tick();
        drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
        check("wrap5.outst", 32'(outstanding), 32'd0);

        // Reset mid-transaction, then a stray response sets the sticky error
        drive(3'b001, 1'b1, 1'b0, '0, 1'b0);
        check("mid.gnt", 32'(core_gnt), 32'b001);
        tick();
        drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
        check("mid.outst_pre", 32'(outstanding), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.outst_rst", 32'(outstanding), 32'd0);
        tick();
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b1, 32'hF000_0000, 1'b0);
        check("stray.rvalid",    32'(core_rvalid), 32'd0);
        check("stray.outst",     32'(outstanding), 32'd0);
        check("stray.proto_pre", 32'(proto_err),   32'd0);
        tick();
        drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
        check("stray.proto_set", 32'(proto_err),   32'd1);
        check("stray.outst2",    32'(outstanding), 32'd0);
        tick();
        drive(3'b011, 1'b0, 1'b0, '0, 1'b0);
        check("stray.sticky",  32'(proto_err), 32'd1);
        check("rst_ptr.addr",  mem_addr,       addr_of(0));
        rst = 1'b1;
        #1;
        check("proto.cleared", 32'(proto_err), 32'd0);
        tick();
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
